// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: elastic valid/ready pipeline register carrying LANES x WIDTH
// payload lanes. SKID=1 adds a skid entry so in_ready comes from a flop.
// Invalid entries always hold zero, so a bubble reads as NOP on every lane.
// A saturating counter tracks cycles where the output is stalled downstream.
module pipe_stage_reg #(
    parameter int WIDTH = 32,
    parameter int LANES = 5,
    parameter int SKID  = 1,
    parameter int CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [LANES*WIDTH-1:0] in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [LANES*WIDTH-1:0] out_data,
    output logic [CNT_W-1:0]       stall_cnt
);

    localparam int DW = LANES * WIDTH;

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_FULL  = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [DW-1:0]   r_main_data;
    logic [DW-1:0]   w_main_nxt;
    logic [DW-1:0]   r_skid_data;
    logic [DW-1:0]   w_skid_nxt;
    logic            r_main_vld;
    logic            r_in_ready;
    logic [CNT_W-1:0] r_stall_cnt;

    logic            w_accept;
    logic            w_fire;
    logic            w_in_ready;

    // SKID=1 uses the flopped ready; SKID=0 lets a consuming downstream
    // make room in the same cycle.
    generate
        if (SKID != 0) begin : g_rdy_reg
            assign w_in_ready = r_in_ready;
        end else begin : g_rdy_comb
            assign w_in_ready = out_ready || !r_main_vld;
        end
    endgenerate

    assign in_ready  = w_in_ready;
    assign out_valid = r_main_vld;
    assign out_data  = r_main_data;
    assign stall_cnt = r_stall_cnt;

    assign w_accept = in_valid && w_in_ready;
    assign w_fire   = r_main_vld && out_ready;

    // Next-state and next-payload selection; flush overrides the handshake.
    always_comb begin
        w_state_nxt = r_state;
        w_main_nxt  = r_main_data;
        w_skid_nxt  = r_skid_data;
        if (flush) begin
            w_state_nxt = S_EMPTY;
            w_main_nxt  = '0;
            w_skid_nxt  = '0;
        end else begin
            case (r_state)
                S_EMPTY: begin
                    if (w_accept) begin
                        w_state_nxt = S_ONE;
                        w_main_nxt  = in_data;
                    end
                end
                S_ONE: begin
                    if (w_accept && w_fire) begin
                        w_main_nxt = in_data;
                    end else if (w_accept && (SKID != 0)) begin
                        // Downstream stalled: park the new payload behind main.
                        w_state_nxt = S_FULL;
                        w_skid_nxt  = in_data;
                    end else if (w_fire) begin
                        w_state_nxt = S_EMPTY;
                        w_main_nxt  = '0;
                    end
                end
                S_FULL: begin
                    if (w_fire) begin
                        w_state_nxt = S_ONE;
                        w_main_nxt  = r_skid_data;
                        w_skid_nxt  = '0;
                    end
                end
                default: begin
                    w_state_nxt = S_EMPTY;
                    w_main_nxt  = '0;
                    w_skid_nxt  = '0;
                end
            endcase
        end
    end

    // State, payload and valid/ready flops; valid and ready are stored
    // directly so the outputs never decode through combinational logic.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_EMPTY;
            r_main_data <= '0;
            r_skid_data <= '0;
            r_main_vld  <= 1'b0;
            r_in_ready  <= 1'b1;
        end else begin
            r_state     <= w_state_nxt;
            r_main_data <= w_main_nxt;
            r_skid_data <= w_skid_nxt;
            r_main_vld  <= (w_state_nxt != S_EMPTY);
            r_in_ready  <= (w_state_nxt != S_FULL);
        end
    end

    // Saturating stall counter; only reset clears it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_stall_cnt <= '0;
        end else if (r_main_vld && !out_ready && !(&r_stall_cnt)) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: a SKID=1 instance (CNT_W=4) and a SKID=0 instance.
// Stimulus pushes the hand-computed expected payload order into per-DUT
// queues; a monitor pops and compares on every output transfer.
module tb_pipe_stage_reg;

    localparam int W  = 32;
    localparam int L  = 5;
    localparam int DW = W * L;

    logic          clk = 1'b0;
    logic          rst1, flush1, in_valid1, out_ready1;
    logic          rst0, flush0, in_valid0, out_ready0;
    logic [DW-1:0] in_data1, in_data0;
    logic          in_ready1, out_valid1, in_ready0, out_valid0;
    logic [DW-1:0] out_data1, out_data0;
    logic [3:0]    stall1;
    logic [15:0]   stall0;

    int n_chk  = 0;
    int n_fail = 0;

    logic [DW-1:0] q1[$];
    logic [DW-1:0] q0[$];

    always #5 clk = ~clk;

    pipe_stage_reg #(.WIDTH(W), .LANES(L), .SKID(1), .CNT_W(4)) dut1 (
        .clk(clk), .reset(rst1), .flush(flush1),
        .in_valid(in_valid1), .in_ready(in_ready1), .in_data(in_data1),
        .out_valid(out_valid1), .out_ready(out_ready1), .out_data(out_data1),
        .stall_cnt(stall1)
    );

    pipe_stage_reg #(.WIDTH(W), .LANES(L), .SKID(0), .CNT_W(16)) dut0 (
        .clk(clk), .reset(rst0), .flush(flush0),
        .in_valid(in_valid0), .in_ready(in_ready0), .in_data(in_data0),
        .out_valid(out_valid0), .out_ready(out_ready0), .out_data(out_data0),
        .stall_cnt(stall0)
    );

    // Distinct value per lane so lane swaps are caught.
    function automatic logic [DW-1:0] mk(input int v);
        logic [DW-1:0] r;
        r = '0;
        for (int k = 0; k < L; k++) r[k*W +: W] = v + (k << 20);
        return r;
    endfunction

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: each output transfer must match the next queued payload;
    // an idle output must read as all-zero.
    initial begin
        forever begin
            @(negedge clk);
            if (out_valid1 && out_ready1) begin
                if (q1.size() == 0) chk("skid1_unexpected_out", out_data1, '0 - 1);
                else chk("skid1_out_data", out_data1, q1.pop_front());
            end else if (!out_valid1) begin
                chk("skid1_idle_zero", out_data1, '0);
            end
            if (out_valid0 && out_ready0) begin
                if (q0.size() == 0) chk("skid0_unexpected_out", out_data0, '0 - 1);
                else chk("skid0_out_data", out_data0, q0.pop_front());
            end else if (!out_valid0) begin
                chk("skid0_idle_zero", out_data0, '0);
            end
        end
    end

    initial begin
        rst1 = 1'b0; flush1 = 1'b0; in_valid1 = 1'b0; out_ready1 = 1'b0; in_data1 = '0;
        rst0 = 1'b0; flush0 = 1'b0; in_valid0 = 1'b0; out_ready0 = 1'b0; in_data0 = '0;

        // Reset held for 3 cycles.
        repeat (3) tick();
        chk("rst_out_valid", DW'(out_valid1), '0);
        chk("rst_out_data", out_data1, '0);
        chk("rst_stall", DW'(stall1), '0);
        chk("rst_in_ready", DW'(in_ready1), 1);
        chk("rst0_in_ready", DW'(in_ready0), 1);
        rst1 = 1'b1; rst0 = 1'b1;

        // Pass-through stream, one per cycle.
        out_ready1 = 1'b1;
        for (int i = 0; i < 8; i++) q1.push_back(mk(32'h1000 + i));
        for (int i = 0; i < 8; i++) begin
            in_valid1 = 1'b1; in_data1 = mk(32'h1000 + i);
            chk("stream_in_ready", DW'(in_ready1), 1);
            tick();
            chk("stream_out_valid", DW'(out_valid1), 1);
        end
        in_valid1 = 1'b0; in_data1 = '0;
        tick();
        chk("stream_drained", DW'(q1.size()), 0);

        // Backpressure into FULL, then drain A, B, C in order.
        out_ready1 = 1'b0;
        q1.push_back(mk(32'hA)); q1.push_back(mk(32'hB)); q1.push_back(mk(32'hC));
        in_valid1 = 1'b1; in_data1 = mk(32'hA); tick();
        in_data1 = mk(32'hB); tick();
        chk("bp_full_in_ready", DW'(in_ready1), 0);
        chk("bp_full_out", out_data1, mk(32'hA));
        in_data1 = mk(32'hC); tick();
        chk("bp_hold_in_ready", DW'(in_ready1), 0);
        out_ready1 = 1'b1; tick();
        chk("bp_ready_back", DW'(in_ready1), 1);
        tick();
        in_valid1 = 1'b0; in_data1 = '0; tick();
        chk("bp_drained", DW'(q1.size()), 0);
        chk("bp_stall", DW'(stall1), 2);

        // Flush while FULL; C presented in the flush cycle is dropped.
        out_ready1 = 1'b0;
        in_valid1 = 1'b1; in_data1 = mk(32'hA); tick();
        in_data1 = mk(32'hB); tick();
        flush1 = 1'b1; in_data1 = mk(32'hC); tick();
        flush1 = 1'b0; in_valid1 = 1'b0; in_data1 = '0;
        chk("flush_out_valid", DW'(out_valid1), 0);
        chk("flush_out_data", out_data1, '0);
        chk("flush_in_ready", DW'(in_ready1), 1);
        chk("flush_stall", DW'(stall1), 4);
        out_ready1 = 1'b1; tick(); tick();
        chk("flush_no_c", DW'(out_valid1), 0);

        // Stall counter saturates at 15 and survives flush.
        out_ready1 = 1'b0;
        in_valid1 = 1'b1; in_data1 = mk(32'hD); tick();
        in_valid1 = 1'b0; in_data1 = '0;
        repeat (10) tick();
        chk("stall_14", DW'(stall1), 14);
        repeat (10) tick();
        chk("stall_sat", DW'(stall1), 15);
        flush1 = 1'b1; tick(); flush1 = 1'b0;
        chk("stall_after_flush", DW'(stall1), 15);
        chk("stall_flush_empty", DW'(out_valid1), 0);

        // Flush together with fire: E is still consumed.
        q1.push_back(mk(32'hE));
        in_valid1 = 1'b1; in_data1 = mk(32'hE); tick();
        in_valid1 = 1'b0; in_data1 = '0;
        flush1 = 1'b1; out_ready1 = 1'b1; tick(); flush1 = 1'b0;
        chk("flush_fire_empty", DW'(out_valid1), 0);
        chk("flush_fire_consumed", DW'(q1.size()), 0);

        // Asynchronous reset between edges while FULL.
        out_ready1 = 1'b0;
        in_valid1 = 1'b1; in_data1 = mk(32'hF); tick();
        in_data1 = mk(32'h10); tick();
        in_valid1 = 1'b0; in_data1 = '0;
        chk("pre_areset_full", DW'(in_ready1), 0);
        #1 rst1 = 1'b0;
        #1;
        chk("areset_out_valid", DW'(out_valid1), 0);
        chk("areset_out_data", out_data1, '0);
        chk("areset_in_ready", DW'(in_ready1), 1);
        chk("areset_stall", DW'(stall1), 0);
        tick(); rst1 = 1'b1;
        q1.push_back(mk(32'h11));
        out_ready1 = 1'b1; in_valid1 = 1'b1; in_data1 = mk(32'h11); tick();
        in_valid1 = 1'b0; in_data1 = '0; tick();
        chk("areset_recover", DW'(q1.size()), 0);

        // SKID=0: combinational ready, back-to-back transfer.
        q0.push_back(mk(32'h5)); q0.push_back(mk(32'h6));
        out_ready0 = 1'b0; in_valid0 = 1'b1; in_data0 = mk(32'h5); tick();
        chk("s0_blocked_ready", DW'(in_ready0), 0);
        out_ready0 = 1'b1; in_data0 = mk(32'h6); #1;
        chk("s0_comb_ready", DW'(in_ready0), 1);
        tick();
        chk("s0_no_bubble", DW'(out_valid0), 1);
        chk("s0_second", out_data0, mk(32'h6));
        in_valid0 = 1'b0; in_data0 = '0; tick();
        chk("s0_empty", DW'(out_valid0), 0);
        chk("s0_drained", DW'(q0.size()), 0);

        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
